// File: rtl/convergence_sequencer_if.sv
// Handshake bundle between the k-means iteration sequencer and its datapath blocks.
// master: sequencer side, drives pass_start, means_ready, cent_num, conv_reg_en, cent_wr_en, conv_regs_reset_n.
// slave : datapath side, drives pass_done, means_valid, converge_res_available, has_converged.
interface convergence_sequencer_if #(
   parameter int CENT_W = 3
);
   logic              pass_start;
   logic              pass_done;
   logic              means_valid;
   logic              means_ready;
   logic [CENT_W-1:0] cent_num;
   logic              conv_reg_en;
   logic              cent_wr_en;
   logic              conv_regs_reset_n;
   logic              converge_res_available;
   logic              has_converged;

   modport master (
      output pass_start, means_ready, cent_num, conv_reg_en, cent_wr_en, conv_regs_reset_n,
      input  pass_done, means_valid, converge_res_available, has_converged
   );

   modport slave (
      input  pass_start, means_ready, cent_num, conv_reg_en, cent_wr_en, conv_regs_reset_n,
      output pass_done, means_valid, converge_res_available, has_converged
   );
endinterface

// File: rtl/convergence_sequencer.sv
// Purpose : k-means iteration controller: CLR -> CLASSIFY -> COLLECT x CENT_NUM -> WAIT_RES -> DECIDE, repeated until converged or iter_max.
// Latency : start to pass_start 1 cycle; minimum pass = 1 + 1 + CENT_NUM + 1 + 1 cycles; DONE adds one cycle.
// Backpressure: means_ready only in COLLECT; each pass_done/means_valid/converge_res_available is waited for (watchdog optional).
// Ports   : clk, rst (sync, active-high); start/abort/iter_max run control; busy/done/converged/iter_count/err status;
//           bus (master modport) carries the classification, new-means and convergence-check handshakes.
// Config  : define CONV_SEQ_WDOG_EN to enable the stall watchdog (WDOG_CYCLES); otherwise err is 0 and waits are unbounded.
module convergence_sequencer #(
   parameter int CENT_NUM    = 8,
   parameter int ITER_WIDTH  = 8,
   parameter int WDOG_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ITER_WIDTH-1:0]  iter_max,
   output logic                   busy,
   output logic                   done,
   output logic                   converged,
   output logic [ITER_WIDTH-1:0]  iter_count,
   output logic                   err,
   convergence_sequencer_if.master bus
);

   localparam int CENT_W = $clog2(CENT_NUM);

   // A single centroid or a one-cycle watchdog makes no sense for this loop.
   if (CENT_NUM < 2 || WDOG_CYCLES < 2) begin : g_bad_cfg
      $error("convergence_sequencer: CENT_NUM and WDOG_CYCLES must be >= 2");
   end

   typedef enum logic [2:0] {
      IDLE, CLR, CLASSIFY, COLLECT, WAIT_RES, DECIDE, DONE
   } state_t;

   state_t                state;
   logic [CENT_W-1:0]     cent_num;
   logic [ITER_WIDTH-1:0] iter_lim;
   logic                  err_q;
   logic                  accept;
   logic                  last_cent;
   logic [ITER_WIDTH:0]   iter_next;
   logic                  wdog_trip;

   assign accept    = bus.means_valid && (state == COLLECT);
   assign last_cent = (cent_num == CENT_W'(CENT_NUM - 1));
   // One extra bit so the limit compare stays correct at iter_max = all-ones.
   assign iter_next = {1'b0, iter_count} + 1'b1;

`ifdef CONV_SEQ_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              watched;
   logic              progress;

   assign watched  = (state == CLASSIFY) || (state == COLLECT) || (state == WAIT_RES);
   assign progress = ((state == CLASSIFY) && bus.pass_done) || accept ||
                     ((state == WAIT_RES) && bus.converge_res_available);
   // Trips on the WDOG_CYCLES-th consecutive stalled cycle.
   assign wdog_trip = watched && !progress && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   // Counter is zero in every unwatched state, so each watched state is entered with a clean count.
   always_ff @(posedge clk) begin
      if (rst || !watched || progress) begin
         wdog_cnt <= '0;
      end else if (!wdog_trip) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cent_num   <= '0;
         iter_count <= '0;
         iter_lim   <= '0;
         converged  <= 1'b0;
         err_q      <= 1'b0;
      end else if (abort) begin
         // Cancel silently: no DONE, iter_count keeps the passes already completed.
         state     <= IDLE;
         cent_num  <= '0;
         converged <= 1'b0;
      end else if (wdog_trip) begin
         err_q     <= 1'b1;
         converged <= 1'b0;
         cent_num  <= '0;
         state     <= DONE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  iter_lim   <= (iter_max == '0) ? ITER_WIDTH'(1) : iter_max;
                  iter_count <= '0;
                  converged  <= 1'b0;
                  err_q      <= 1'b0;
                  state      <= CLR;
               end
            end
            CLR: begin
               cent_num <= '0;
               state    <= CLASSIFY;
            end
            CLASSIFY: begin
               if (bus.pass_done) begin
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  if (last_cent) begin
                     cent_num <= '0;
                     state    <= WAIT_RES;
                  end else begin
                     cent_num <= cent_num + 1'b1;
                  end
               end
            end
            WAIT_RES: begin
               if (bus.converge_res_available) begin
                  converged <= bus.has_converged;
                  state     <= DECIDE;
               end
            end
            DECIDE: begin
               iter_count <= iter_next[ITER_WIDTH-1:0];
               if (converged || (iter_next >= {1'b0, iter_lim})) begin
                  state <= DONE;
               end else begin
                  state <= CLR;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Moore outputs decoded from the state register; only the accept strobes follow means_valid.
   assign busy                  = (state != IDLE);
   assign done                  = (state == DONE);
   assign err                   = err_q;
   assign bus.pass_start        = (state == CLR);
   assign bus.conv_regs_reset_n = (state != CLR);
   assign bus.means_ready       = (state == COLLECT);
   assign bus.conv_reg_en       = accept;
   assign bus.cent_wr_en        = accept;
   assign bus.cent_num          = cent_num;

endmodule
